// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, default
// timing parameters and a small sizing helper.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } pll_state_t;

  localparam int DEF_RST_PULSE    = 16;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_CORE_HOLD    = 256;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the refclk domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and core reset release, retrying on
// lock timeout or lock loss.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE    = DEF_RST_PULSE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int CORE_HOLD    = DEF_CORE_HOLD
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       lock_ok,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int CNT_MAX = max4(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE, CORE_HOLD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Each state's terminal count is its duration minus one, so the largest
  // duration still fits in CNT_W bits.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CORE_HOLD - 1);

  logic             w_locked_s;
  pll_state_t       w_next;
  logic             w_bump;
  logic             w_change;

  pll_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_core_rst;
  logic             r_lock_ok;
  logic [3:0]       r_retry;

  sync_2ff u_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  always_comb begin
    w_next = r_state;
    w_bump = 1'b0;
    if (restart) begin
      w_next = ST_PLL_RST;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == RST_LAST) w_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next = ST_STABLE;
          end else if (r_cnt == TO_LAST) begin
            w_next = ST_PLL_RST;
            w_bump = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s)             w_next = ST_WAIT_LOCK;
          else if (r_cnt == STB_LAST)  w_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (!w_locked_s) begin
            w_next = ST_PLL_RST;
            w_bump = 1'b1;
          end else if (r_cnt == HOLD_LAST) begin
            w_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_next = ST_PLL_RST;
            w_bump = 1'b1;
          end
        end
        default: w_next = ST_PLL_RST;
      endcase
    end
    w_change = restart || (w_next != r_state);
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_PLL_RST;
      r_cnt      <= '0;
      r_pll_rst  <= 1'b1;
      r_core_rst <= 1'b1;
      r_lock_ok  <= 1'b0;
      r_retry    <= 4'd0;
    end else begin
      r_state    <= w_next;
      r_pll_rst  <= (w_next == ST_PLL_RST);
      r_core_rst <= (w_next != ST_RUN);
      r_lock_ok  <= (w_next == ST_RUN);
      if (w_change)
        r_cnt <= '0;
      else if (r_state != ST_RUN)
        r_cnt <= r_cnt + 1'b1;
      if (w_bump && (r_retry != RETRY_MAX))
        r_retry <= r_retry + 4'd1;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign core_rst  = r_core_rst;
  assign lock_ok   = r_lock_ok;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule
